// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int MIN_RATIO = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: active/shadow ratio, period counter and registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] ratio_i,
  input  logic             load_i,
  output logic             div_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] MinR = CNT_W'(MIN_RATIO);
  localparam logic [CNT_W-1:0] One  = CNT_W'(1);

  ch_state_e        state_q;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W-1:0] shd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             div_q;
  logic             tick_q;
  logic             run;
  logic             at_wrap;
  logic             xfer;

  // High phase length: ceil(a/2).
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] a);
    return (a >> 1) + {{(CNT_W-1){1'b0}}, a[0]};
  endfunction

  assign run     = en_i && (act_q >= MinR);
  assign at_wrap = (cnt_q == (act_q - One));

  // A fresh load always defers the transfer, so a strobe landing on a wrap waits one more period.
  assign xfer    = pend_q && !load_i && (!run || at_wrap);

  always_comb begin
    cnt_d = '0;
    if (run && !at_wrap) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      shd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      if (load_i) begin
        shd_q  <= ratio_i;
        pend_q <= 1'b1;
      end else if (xfer) begin
        act_q  <= shd_q;
        pend_q <= 1'b0;
      end
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= RUN;
            tick_q  <= 1'b1;
            div_q   <= 1'b1;
          end else begin
            tick_q  <= 1'b0;
            div_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!run) begin
            state_q <= IDLE;
            tick_q  <= 1'b0;
            div_q   <= 1'b0;
          end else begin
            tick_q  <= (cnt_q == '0);
            div_q   <= (cnt_q < high_len(act_q));
          end
        end
        default: begin
          state_q <= IDLE;
          tick_q  <= 1'b0;
          div_q   <= 1'b0;
        end
      endcase
    end
  end

  assign div_out_o = div_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: slices the ratio bus and wires up one channel per lane.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] ratio,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[g]),
      .ratio_i  (ratio[g*CNT_W +: CNT_W]),
      .load_i   (load[g]),
      .div_out_o(div_out[g]),
      .tick_o   (tick[g]),
      .pending_o(pending[g])
    );
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 8: width of each channel's divide-ratio field and internal counter.
REQ-003 Port clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port en, input, NUM_CH: per-channel run enable.
REQ-006 Port ratio, input, NUM_CH*CNT_W: per-channel divide ratio N; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-007 Port load, input, NUM_CH: per-channel one-cycle strobe that captures ratio into the shadow register.
REQ-008 Port div_out, output, NUM_CH: per-channel divided clock, registered and glitch-free.
REQ-009 Port tick, output, NUM_CH: per-channel one-cycle pulse marking the first clk cycle of each div_out period.
REQ-010 Port pending, output, NUM_CH: high from a load until the shadow ratio is applied.

Function
REQ-011 Each channel shall hold an active ratio A, a shadow ratio S and a counter C of CNT_W bits.
- C counts 0..A-1 while running.
- C wraps to 0 after A-1.
REQ-012 div_out shall be high for C in 0..ceil(A/2)-1 and low for all other C.
- Period is exactly A clk cycles.
- Duty is 50% for even A; for odd A, high lasts (A+1)/2 cycles.
REQ-013 tick shall be high exactly in cycles where C==0 and the channel is running.
REQ-014 Latency: div_out and tick shall be registered, with one clk cycle of latency from the counter state.
REQ-015 A load on channel i shall write S in the cycle after the strobe and set pending.
REQ-016 S shall be transferred to A, and pending cleared, only at the wrap from A-1 to 0, so no period is truncated or stretched.
REQ-017 A load while pending is already set shall overwrite S (last-writer-wins); the transfer timing is unchanged.
REQ-018 If load and a wrap occur in the same cycle, the new ratio shall apply at the following wrap, not the current one.
REQ-019 If en is low or A<2, the channel shall be idle.
- Idle means C=0, div_out=0, tick=0.
- A pending S shall transfer to A immediately while idle.
REQ-020 When en rises with A>=2, tick and div_out shall go high in the next cycle (C=0), starting a full period.
REQ-021 When en falls mid-period, the channel shall go idle in the next cycle; a truncated high phase is permitted.
REQ-022 Channels shall be fully independent; activity on one channel shall never affect another.

Reset
REQ-023 While rst is high, every channel shall asynchronously set A=0, S=0, C=0, div_out=0, tick=0 and pending=0.
REQ-024 Asserting rst mid-period shall discard any pending ratio; after release, a channel shall run only after a new load.

Structure
REQ-025 Package clk_div_pkg shall hold the CNT_W default, the minimum-ratio constant MIN_RATIO=2 and the channel state enum.
- Enum values: IDLE, RUN.
REQ-026 The per-channel logic shall be sub-module clk_div_channel, instantiated NUM_CH times by a generate loop; the top contains only slicing and wiring.

Verification
REQ-027 Load ratio=4 on ch0 and raise en -> div_out0 repeats 2 high / 2 low; tick0 every 4 cycles.
REQ-028 Load ratio=5 on ch1 -> div_out1 repeats 3 high / 2 low; period 5 cycles.
REQ-029 While running at ratio 6, load ratio 2 in mid-period -> current 6-cycle period completes, then period 2 follows; pending high exactly until that wrap.
REQ-030 Load ratio 0 or 1 -> channel idle with div_out=0 and tick=0; load 8 then raise en -> 8-cycle periods.
REQ-031 Assert rst for 1 cycle mid-period on all channels -> all outputs 0 immediately; no output until a new load and en.
REQ-032 Drive all four channels at ratios 2, 3, 7 and 255 concurrently for 2000 cycles -> each period is exact; tick count per channel equals floor(cycles/ratio) ±1.
